uart_tx_arb: RTL

Round-robin arbiter and sequencer that shares one byte-wide UART transmitter (`uart`: `wdata`/`wdata_ready`/`stop`) among `N_REQ` requesters, such as CPU MMIO, a debug monitor and a boot-log streamer. It accepts a byte from the winning requester with a valid/ready handshake, issues it to the UART and waits for the frame to complete. Only then does it re-arbitrate. It sits between the peripheral requesters and the UART on the UART clock domain.

---
 rtl/uart_arb_pkg.sv | 16 +
 rtl/uart_tx_arb_rr_pick.sv | 40 ++++
 rtl/uart_tx_arb.sv | 139 +++++++++++++
 3 files changed

// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART transmit arbiter.
// Optional feature macro used by the arbiter: UART_ARB_LOCK_EN (packet lock).
package uart_arb_pkg;

    // Arbiter sequencing states.
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } uart_arb_state_t;

    // UART frame length seen on uart_stop: one start bit plus eight data bits.
    localparam int unsigned UART_ARB_FRAME_CYCLES = 9;

endpackage

// File: rtl/uart_tx_arb_rr_pick.sv
// Combinational round-robin picker: searches upward from ptr with wrap and
// returns the first requester found, as a one-hot grant and a binary index.
// An optional force mask restricts the candidates (used for packet lock).
module rr_pick #(
    parameter int unsigned N  = 2,
    parameter int unsigned IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    input  logic          force_en_i,
    input  logic [N-1:0]  force_mask_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    logic [N-1:0] eff_req;

    // Candidates after the optional force mask.
    assign eff_req = force_en_i ? (req_i & force_mask_i) : req_i;

    // Walk from farthest to nearest offset so the nearest hit overwrites.
    always_comb begin
        int c;
        c     = 0;
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        for (int off = int'(N) - 1; off >= 0; off--) begin
            c = (int'(ptr_i) + off) % int'(N);
            if (eff_req[c]) begin
                gnt_o    = '0;
                gnt_o[c] = 1'b1;
                idx_o    = c[IW-1:0];
                any_o    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter/sequencer sharing one byte-wide UART transmitter among
// N_REQ requesters. One byte is accepted, issued, and the frame is awaited
// before the next arbitration.
// Optional feature: define UART_ARB_LOCK_EN to hold the grant on one
// requester until it sends a byte flagged with req_last.
//
// Handshake: a byte moves from requester i when req_valid_i[i] and
// req_ready_o[i] are both high on a rising clk edge; req_ready_o is
// combinational, only in IDLE, only with uart_stop_i high, at most one-hot.
module uart_tx_arb
    import uart_arb_pkg::*;
#(
    parameter int unsigned N_REQ = 2,
    parameter int unsigned ID_W  = $clog2(N_REQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_REQ-1:0]     req_valid_i,
    input  logic [8*N_REQ-1:0]   req_data_i,
    input  logic [N_REQ-1:0]     req_last_i,
    output logic [N_REQ-1:0]     req_ready_o,
    output logic [7:0]           uart_wdata_o,
    output logic                 uart_wdata_ready_o,
    input  logic                 uart_stop_i,
    output logic                 busy_o,
    output logic [ID_W-1:0]      grant_id_o
);

    uart_arb_state_t state_q, state_d;
    logic [ID_W-1:0] ptr_q, ptr_d;
    logic [ID_W-1:0] gid_q, gid_d;
    logic [7:0]      wdata_q, wdata_d;
    logic            wready_q;
    logic            accept;

    logic [N_REQ-1:0] pick_gnt;
    logic [ID_W-1:0]  pick_idx;
    logic             pick_any;
    logic             force_en;
    logic [N_REQ-1:0] force_mask;

`ifdef UART_ARB_LOCK_EN
    logic            lock_q, lock_d;
    logic [ID_W-1:0] lock_id_q, lock_id_d;

    assign force_en   = lock_q;
    assign force_mask = {{(N_REQ-1){1'b0}}, 1'b1} << lock_id_q;

    // Lock is taken by a byte without req_last and released by one with it.
    always_comb begin
        lock_d    = lock_q;
        lock_id_d = lock_id_q;
        if (accept) begin
            lock_d    = ~req_last_i[pick_idx];
            lock_id_d = pick_idx;
        end
    end

    // Lock registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_q    <= 1'b0;
            lock_id_q <= '0;
        end else begin
            lock_q    <= lock_d;
            lock_id_q <= lock_id_d;
        end
    end
`else
    logic unused_last;

    assign unused_last = ^req_last_i;
    assign force_en    = 1'b0;
    assign force_mask  = '0;
`endif

    rr_pick #(
        .N  (N_REQ),
        .IW (ID_W)
    ) u_pick (
        .req_i        (req_valid_i),
        .ptr_i        (ptr_q),
        .force_en_i   (force_en),
        .force_mask_i (force_mask),
        .gnt_o        (pick_gnt),
        .idx_o        (pick_idx),
        .any_o        (pick_any)
    );

    // Next state, accept handshake and latched byte/grant values.
    // rst_n gates the accept so no requester sees ready while held in reset.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        gid_d       = gid_q;
        wdata_d     = wdata_q;
        req_ready_o = '0;
        accept      = 1'b0;
        case (state_q)
            IDLE: begin
                if (rst_n && uart_stop_i && pick_any) begin
                    req_ready_o = pick_gnt;
                    accept      = 1'b1;
                    wdata_d     = req_data_i[{pick_idx, 3'b000} +: 8];
                    gid_d       = pick_idx;
                    ptr_d       = (pick_idx == ID_W'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;
                    state_d     = ISSUE;
                end
            end
            ISSUE:     state_d = WAIT_BUSY;
            WAIT_BUSY: if (!uart_stop_i) state_d = WAIT_DONE;
            WAIT_DONE: if (uart_stop_i) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // State and output registers; the start pulse is high exactly while in ISSUE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            gid_q    <= '0;
            wdata_q  <= 8'h00;
            wready_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            gid_q    <= gid_d;
            wdata_q  <= wdata_d;
            wready_q <= (state_d == ISSUE);
        end
    end

    assign uart_wdata_o       = wdata_q;
    assign uart_wdata_ready_o = wready_q;
    assign grant_id_o         = gid_q;
    assign busy_o             = (state_q != IDLE);

endmodule
